// File: rtl/acc_exec_unit.sv
// Execute stage of the 8-bit accumulator CPU: instruction handshake, RF strobes,
// accumulator/flag update and the IDLE/DEC/EXE/HALT control sequence.
module acc_exec_unit #(
    parameter int unsigned REG_ADDR_WIDTH = 2,
    parameter logic [7:0]  ACC_RESET      = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                instr,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [7:0]                rf_data,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr,
    output logic                      rf_ld_ce,
    output logic                      rf_st_ce,
    output logic [7:0]                acc,
    output logic                      flag_z,
    output logic                      flag_c,
    output logic                      retire,
    output logic                      illegal,
    output logic                      halted,
    input  logic                      resume
);

    typedef enum logic [1:0] {S_IDLE, S_DEC, S_EXE, S_HALT} state_t;

    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t                    r_state;
    logic [7:0]                r_ir;
    logic [7:0]                r_acc;
    logic                      r_flag_z;
    logic                      r_flag_c;
    logic [REG_ADDR_WIDTH-1:0] r_rf_addr;
    logic                      r_rf_ld_ce;
    logic                      r_rf_st_ce;
    logic                      r_ready;
    logic                      r_retire;
    logic                      r_illegal;
    logic                      r_halted;

    logic [3:0] w_op;
    logic [3:0] w_in_op;
    logic       w_in_needs_rf;
    logic       w_needs_rf;
    logic       w_illegal;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [7:0] w_acc_nxt;
    logic       w_c_nxt;
    logic       w_z_nxt;
    logic       w_wr;

    assign w_op          = r_ir[7:4];
    assign w_in_op       = instr[7:4];
    assign w_in_needs_rf = (w_in_op == OP_LD) || ((w_in_op >= OP_ADD) && (w_in_op <= OP_XOR));
    assign w_needs_rf    = (w_op == OP_LD) || ((w_op >= OP_ADD) && (w_op <= OP_XOR));
    assign w_illegal     = (w_op >= 4'hB) && (w_op <= 4'hE);
    assign w_sum         = {1'b0, r_acc} + {1'b0, rf_data};
    // Bit 8 of the 9-bit difference is the borrow, i.e. acc < rf_data.
    assign w_diff        = {1'b0, r_acc} - {1'b0, rf_data};

    // Next accumulator/flag values for the opcode held in ir.
    always_comb begin
        w_acc_nxt = r_acc;
        w_c_nxt   = r_flag_c;
        w_wr      = 1'b0;
        case (w_op)
            OP_LD:  begin w_acc_nxt = rf_data;                      w_wr = 1'b1; end
            OP_ADD: begin {w_c_nxt, w_acc_nxt} = w_sum;             w_wr = 1'b1; end
            OP_SUB: begin {w_c_nxt, w_acc_nxt} = w_diff;            w_wr = 1'b1; end
            OP_AND: begin w_acc_nxt = r_acc & rf_data; w_c_nxt = 1'b0; w_wr = 1'b1; end
            OP_OR:  begin w_acc_nxt = r_acc | rf_data; w_c_nxt = 1'b0; w_wr = 1'b1; end
            OP_XOR: begin w_acc_nxt = r_acc ^ rf_data; w_c_nxt = 1'b0; w_wr = 1'b1; end
            OP_LDI: begin w_acc_nxt = {4'h0, r_ir[3:0]};            w_wr = 1'b1; end
            OP_SHL: begin w_acc_nxt = {r_acc[6:0], 1'b0}; w_c_nxt = r_acc[7]; w_wr = 1'b1; end
            OP_SHR: begin w_acc_nxt = {1'b0, r_acc[7:1]}; w_c_nxt = r_acc[0]; w_wr = 1'b1; end
            default: ;
        endcase
        w_z_nxt = (w_acc_nxt == 8'h00);
    end

    // Control FSM; all strobes are set up on the edge entering the state that uses them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ir       <= 8'h00;
            r_acc      <= ACC_RESET;
            r_flag_z   <= 1'b0;
            r_flag_c   <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_ld_ce <= 1'b0;
            r_rf_st_ce <= 1'b0;
            r_ready    <= 1'b1;
            r_retire   <= 1'b0;
            r_illegal  <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_retire  <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_ir       <= instr;
                        r_rf_addr  <= instr[REG_ADDR_WIDTH-1:0];
                        r_rf_ld_ce <= w_in_needs_rf;
                        r_rf_st_ce <= (w_in_op == OP_ST);
                        r_ready    <= 1'b0;
                        r_state    <= S_DEC;
                    end
                end
                S_DEC: begin
                    r_rf_st_ce <= 1'b0;
                    if (w_needs_rf) begin
                        r_state <= S_EXE;
                    end else begin
                        r_retire  <= 1'b1;
                        r_illegal <= w_illegal;
                        if (w_wr) begin
                            r_acc    <= w_acc_nxt;
                            r_flag_c <= w_c_nxt;
                            r_flag_z <= w_z_nxt;
                        end
                        if (w_op == OP_HALT) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_EXE: begin
                    r_rf_ld_ce <= 1'b0;
                    r_acc      <= w_acc_nxt;
                    r_flag_c   <= w_c_nxt;
                    r_flag_z   <= w_z_nxt;
                    r_retire   <= 1'b1;
                    r_ready    <= 1'b1;
                    r_state    <= S_IDLE;
                end
                S_HALT: begin
                    if (resume) begin
                        r_halted <= 1'b0;
                        r_ready  <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign rf_addr     = r_rf_addr;
    assign rf_ld_ce    = r_rf_ld_ce;
    assign rf_st_ce    = r_rf_st_ce;
    assign acc         = r_acc;
    assign flag_z      = r_flag_z;
    assign flag_c      = r_flag_c;
    assign retire      = r_retire;
    assign illegal     = r_illegal;
    assign halted      = r_halted;

endmodule
